// File: rtl/alu_share_pkg.sv
// Shared encodings for the two-requester shared-ALU controller.
// Op codes, FSM states and requester-id width live here.
package alu_share_pkg;

   localparam int ID_W = 1;

   typedef logic [ID_W-1:0] id_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_4bit.sv
// 4-bit combinational ALU with zero/carry/overflow flags.
// Carry is the borrow on subtract and the shifted-out bit on shifts.
module alu_4bit
   import alu_share_pkg::*;
(
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [2:0] ALU_Sel,
   output logic [3:0] ALU_Result,
   output logic       Zero,
   output logic       Carry,
   output logic       Overflow
);

   logic [4:0] w_sum;
   logic [4:0] w_dif;

   assign w_sum = {1'b0, A} + {1'b0, B};
   assign w_dif = {1'b0, A} - {1'b0, B};

   always_comb begin
      ALU_Result = 4'h0;
      Carry      = 1'b0;
      Overflow   = 1'b0;
      case (ALU_Sel)
         OP_ADD: begin
            ALU_Result = w_sum[3:0];
            Carry      = w_sum[4];
            Overflow   = (A[3] == B[3]) && (w_sum[3] != A[3]);
         end
         OP_SUB: begin
            ALU_Result = w_dif[3:0];
            Carry      = w_dif[4];
            Overflow   = (A[3] != B[3]) && (w_dif[3] != A[3]);
         end
         OP_AND: ALU_Result = A & B;
         OP_OR:  ALU_Result = A | B;
         OP_XOR: ALU_Result = A ^ B;
         OP_NOT: ALU_Result = ~A;
         OP_SHL: begin
            ALU_Result = {A[2:0], 1'b0};
            Carry      = A[3];
         end
         OP_SHR: begin
            ALU_Result = {1'b0, A[3:1]};
            Carry      = A[0];
         end
         default: ALU_Result = 4'h0;
      endcase
   end

   assign Zero = (ALU_Result == 4'h0);

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter; priority moves only when told a
// transaction for a given requester has completed.
module alu_rr_arb2
   import alu_share_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_upd,
   input  id_t  i_upd_id,
   output logic o_gnt_any,
   output id_t  o_gnt_id
);

   id_t r_prio;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= '0;
      end else if (i_upd) begin
         r_prio <= ~i_upd_id;
      end
   end

   assign o_gnt_any = i_req0 | i_req1;
   assign o_gnt_id  = (i_req0 & i_req1) ? r_prio : id_t'(i_req1);

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one alu_4bit between two requesters, one op in flight,
// with a registered response handshake and per-requester counters.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [2:0]       req0_op,
   input  logic [2:0]       req1_op,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [3:0]       rsp_result,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             rsp_overflow,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   state_t           r_state;
   op_t              r_op;
   logic [3:0]       r_a;
   logic [3:0]       r_b;
   id_t              r_id;
   logic             r_rsp_valid;
   id_t              r_rsp_id;
   logic [3:0]       r_rsp_res;
   logic             r_rsp_z;
   logic             r_rsp_c;
   logic             r_rsp_v;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic             w_gnt_any;
   id_t              w_gnt_id;
   logic             w_take;
   logic             w_hs;
   logic [3:0]       w_res;
   logic             w_z;
   logic             w_c;
   logic             w_v;

   alu_rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req0    (req0_valid),
      .i_req1    (req1_valid),
      .i_upd     (w_hs),
      .i_upd_id  (r_rsp_id),
      .o_gnt_any (w_gnt_any),
      .o_gnt_id  (w_gnt_id)
   );

   alu_4bit u_alu (
      .A          (r_a),
      .B          (r_b),
      .ALU_Sel    (r_op),
      .ALU_Result (w_res),
      .Zero       (w_z),
      .Carry      (w_c),
      .Overflow   (w_v)
   );

   // rst_n gate keeps ready low while reset holds the FSM in IDLE
   assign w_take     = rst_n & (r_state == S_IDLE) & w_gnt_any;
   assign req0_ready = w_take & (w_gnt_id == 1'b0);
   assign req1_ready = w_take & (w_gnt_id == 1'b1);
   assign w_hs       = r_rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_op        <= OP_ADD;
         r_a         <= 4'h0;
         r_b         <= 4'h0;
         r_id        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_res   <= 4'h0;
         r_rsp_z     <= 1'b0;
         r_rsp_c     <= 1'b0;
         r_rsp_v     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  r_op    <= op_t'(w_gnt_id ? req1_op : req0_op);
                  r_a     <= w_gnt_id ? req1_a : req0_a;
                  r_b     <= w_gnt_id ? req1_b : req0_b;
                  r_id    <= w_gnt_id;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_res   <= w_res;
               r_rsp_z     <= w_z;
               r_rsp_c     <= w_c;
               r_rsp_v     <= w_v;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (cnt_clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (w_hs) begin
         if (r_rsp_id == 1'b0 && r_cnt0 != '1)
            r_cnt0 <= r_cnt0 + CNT_W'(1);
         if (r_rsp_id == 1'b1 && r_cnt1 != '1)
            r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_id       = r_rsp_id;
   assign rsp_result   = r_rsp_res;
   assign rsp_zero     = r_rsp_z;
   assign rsp_carry    = r_rsp_c;
   assign rsp_overflow = r_rsp_v;
   assign done_cnt0    = r_cnt0;
   assign done_cnt1    = r_cnt1;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: transaction-timing model checked every
// cycle on two instances (CNT_W=8 and CNT_W=2) plus literal checks.
module tb_alu_share_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [2:0] req0_op, req1_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp_ready;
   logic       cnt_clr;

   logic       a_r0, a_r1, a_rv, a_id, a_z, a_c, a_v;
   logic [3:0] a_res;
   logic [7:0] a_d0, a_d1;
   logic       b_r0, b_r1, b_rv, b_id, b_z, b_c, b_v;
   logic [3:0] b_res;
   logic [1:0] b_d0, b_d1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(a_r0), .req1_ready(a_r1),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(a_rv), .rsp_ready(rsp_ready),
      .rsp_id(a_id), .rsp_result(a_res),
      .rsp_zero(a_z), .rsp_carry(a_c), .rsp_overflow(a_v),
      .cnt_clr(cnt_clr), .done_cnt0(a_d0), .done_cnt1(a_d1)
   );

   alu_share_ctrl #(.CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(b_r0), .req1_ready(b_r1),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(b_rv), .rsp_ready(rsp_ready),
      .rsp_id(b_id), .rsp_result(b_res),
      .rsp_zero(b_z), .rsp_carry(b_c), .rsp_overflow(b_v),
      .cnt_clr(cnt_clr), .done_cnt0(b_d0), .done_cnt1(b_d1)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic int sgn(input int x);
      return (x > 7) ? x - 16 : x;
   endfunction

   // Reference ALU from the arithmetic definitions of each op
   task automatic ref_alu(input int op, input int a, input int b,
                          output int r, output int z, output int c,
                          output int v);
      int s;
      c = 0;
      v = 0;
      case (op)
         0: begin
            s = a + b; r = s % 16; c = (s > 15);
            v = (sgn(a) + sgn(b) > 7) || (sgn(a) + sgn(b) < -8);
         end
         1: begin
            r = (a - b + 16) % 16; c = (a < b);
            v = (sgn(a) - sgn(b) > 7) || (sgn(a) - sgn(b) < -8);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 15 - a;
         6: begin r = (a * 2) % 16; c = (a >= 8); end
         default: begin r = a / 2; c = a % 2; end
      endcase
      z = (r == 0);
   endtask

   // Model: in-flight flag, cycles since acceptance, RR favourite.
   int m_busy, m_age, m_id, m_op, m_a, m_b, m_prio;
   int m_res, m_z, m_c, m_v, m_rid;
   int m_c8 [2];
   int m_c2 [2];
   int e_g, e_r0, e_r1, e_rv;

   task automatic model_reset();
      m_busy = 0; m_age = 0; m_id = 0; m_prio = 0;
      m_res = 0; m_z = 0; m_c = 0; m_v = 0; m_rid = 0;
      m_c8[0] = 0; m_c8[1] = 0; m_c2[0] = 0; m_c2[1] = 0;
   endtask

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      e_r0 = 0; e_r1 = 0; e_g = 0;
      if (rst_n && !m_busy && (req0_valid || req1_valid)) begin
         e_g = (req0_valid && req1_valid) ? m_prio : int'(req1_valid);
         e_r0 = (e_g == 0);
         e_r1 = (e_g == 1);
      end
      e_rv = (rst_n && m_busy && m_age == 2);
      chk("a_ready0", a_r0, e_r0);   chk("b_ready0", b_r0, e_r0);
      chk("a_ready1", a_r1, e_r1);   chk("b_ready1", b_r1, e_r1);
      chk("a_rsp_valid", a_rv, e_rv); chk("b_rsp_valid", b_rv, e_rv);
      chk("a_rsp_id", a_id, m_rid);  chk("b_rsp_id", b_id, m_rid);
      chk("a_result", a_res, m_res); chk("b_result", b_res, m_res);
      chk("a_zero", a_z, m_z);       chk("b_zero", b_z, m_z);
      chk("a_carry", a_c, m_c);      chk("b_carry", b_c, m_c);
      chk("a_ovf", a_v, m_v);        chk("b_ovf", b_v, m_v);
      chk("a_cnt0", a_d0, m_c8[0]);  chk("a_cnt1", a_d1, m_c8[1]);
      chk("b_cnt0", b_d0, m_c2[0]);  chk("b_cnt1", b_d1, m_c2[1]);
      if (rst_n) begin
         if (m_busy && m_age == 1) begin
            ref_alu(m_op, m_a, m_b, m_res, m_z, m_c, m_v);
            m_rid = m_id;
            m_age = 2;
         end else if (e_rv && rsp_ready) begin
            if (m_c8[m_rid] < 255) m_c8[m_rid]++;
            if (m_c2[m_rid] < 3) m_c2[m_rid]++;
            m_prio = 1 - m_rid;
            m_busy = 0;
         end else if (e_r0 || e_r1) begin
            m_busy = 1; m_age = 1; m_id = e_g;
            m_op = e_g ? req1_op : req0_op;
            m_a  = e_g ? req1_a : req0_a;
            m_b  = e_g ? req1_b : req0_b;
         end
         if (cnt_clr) begin
            m_c8[0] = 0; m_c8[1] = 0; m_c2[0] = 0; m_c2[1] = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int id, input int op, input int a,
                        input int b);
      if (id == 0) begin
         req0_valid = 1; req0_op = op[2:0];
         req0_a = a[3:0]; req0_b = b[3:0];
      end else begin
         req1_valid = 1; req1_op = op[2:0];
         req1_a = a[3:0]; req1_b = b[3:0];
      end
   endtask

   task automatic idle_reqs();
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic run_op(input int id, input int op, input int a,
                         input int b);
      drive(id, op, a, b);
      step();
      idle_reqs();
      step();
      step();
   endtask

   int ids[$];
   int hold_res;

   initial begin
      rst_n = 0; rsp_ready = 1; cnt_clr = 0;
      req0_valid = 0; req1_valid = 0;
      req0_op = 0; req1_op = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      step(); step(); step();
      rst_n = 1;
      step();
      @(negedge clk);
      chk("lit_reset_valid", a_rv, 0);
      chk("lit_reset_result", a_res, 0);

      // add 7+1 from req0
      step();
      drive(0, 0, 7, 1);
      @(negedge clk);
      chk("lit_add_ready0", a_r0, 1);
      step(); idle_reqs(); step();
      @(negedge clk);
      chk("lit_add_valid", a_rv, 1);
      chk("lit_add_id", a_id, 0);
      chk("lit_add_res", a_res, 8);
      chk("lit_add_ovf", a_v, 1);
      chk("lit_add_zero", a_z, 0);
      step();

      // add F+1 from req1
      drive(1, 0, 15, 1);
      @(negedge clk);
      chk("lit_wrap_ready1", a_r1, 1);
      step(); idle_reqs(); step();
      @(negedge clk);
      chk("lit_wrap_res", a_res, 0);
      chk("lit_wrap_zero", a_z, 1);
      chk("lit_wrap_carry", a_c, 1);
      chk("lit_wrap_id", a_id, 1);
      step();
      @(negedge clk);
      chk("lit_wrap_cnt1", a_d1, 1);
      step();

      // both requesters continuously
      cnt_clr = 1; step(); cnt_clr = 0;
      drive(0, 1, 3, 5);
      drive(1, 2, 12, 10);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (a_rv && rsp_ready) ids.push_back(int'(a_id));
         step();
      end
      idle_reqs();
      chk("lit_rr_count", ids.size(), 4);
      for (int i = 0; i < 4 && i < ids.size(); i++)
         chk("lit_rr_id", ids[i], i % 2);
      @(negedge clk);
      chk("lit_rr_cnt0", a_d0, 2);
      chk("lit_rr_cnt1", a_d1, 2);
      chk("lit_rr_b_cnt0", b_d0, 2);
      step();

      // back-pressure in RESP
      drive(0, 3, 5, 10);
      rsp_ready = 0;
      step(); idle_reqs(); step();
      req1_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) hold_res = int'(a_res);
         chk("lit_hold_valid", a_rv, 1);
         chk("lit_hold_res", a_res, 15);
         chk("lit_hold_stable", a_res, hold_res);
         chk("lit_hold_ready1", a_r1, 0);
         chk("lit_hold_cnt0", a_d0, 2);
         step();
      end
      rsp_ready = 1;
      req1_valid = 0;
      step();
      @(negedge clk);
      chk("lit_hold_done", a_rv, 0);
      chk("lit_hold_cnt0_after", a_d0, 3);
      step();

      // reset during EXEC
      drive(0, 0, 1, 2);
      step(); idle_reqs();
      rst_n = 0;
      step(); step();
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lit_rst_no_rsp", a_rv, 0);
         step();
      end
      chk("lit_rst_cnt0", a_d0, 0);
      chk("lit_rst_cnt1", a_d1, 0);
      drive(0, 4, 10, 5);
      step(); idle_reqs(); step();
      @(negedge clk);
      chk("lit_xor_res", a_res, 15);
      step();

      // saturation on the narrow instance, clear beats handshake
      cnt_clr = 1; step(); cnt_clr = 0;
      for (int i = 0; i < 4; i++) run_op(0, 0, i, i);
      @(negedge clk);
      chk("lit_sat_b_cnt0", b_d0, 3);
      chk("lit_sat_a_cnt0", a_d0, 4);
      step();
      drive(0, 6, 9, 0);
      step(); idle_reqs(); step();
      cnt_clr = 1;
      step();
      cnt_clr = 0;
      @(negedge clk);
      chk("lit_clr_b_cnt0", b_d0, 0);
      chk("lit_clr_a_cnt0", a_d0, 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
